// File: rtl/mcycle_seq_if.sv
// Request/result bundle between the decoder and the iterative multiply/divide unit.
// Start is a request. Busy is its stall: an operation is accepted on the edge where
// Start is high in IDLE and RESET is low. Done pulses once when Result1/Result2 update.
interface mcycle_seq_if #(parameter int WIDTH = 32);
    logic             Start;
    logic             MCycleOp;
    logic             Signed;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Signed, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Signed, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );
endinterface

// File: rtl/mcycle_seq.sv
// Iterative multiply/divide unit: WIDTH shift-add or restoring-divide steps on operand
// magnitudes, followed by one sign-fixup cycle. state_o exposes the FSM state for debug.
module mcycle_seq #(
    parameter int WIDTH = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    mcycle_seq_if.slave  bus,
    output logic [1:0]   state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, COMPUTE = 2'd1, FIXUP = 2'd2} state_t;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, op1_raw_q;
    logic [WIDTH-1:0]   result1_q, result2_q, res1_d, res2_d;
    logic               is_div_q, neg_res_q, neg_rem_q, dz_q, done_q;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     add_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] prod_fix;

    assign mag1 = (bus.Signed && bus.Operand1[WIDTH-1]) ? -bus.Operand1 : bus.Operand1;
    assign mag2 = (bus.Signed && bus.Operand2[WIDTH-1]) ? -bus.Operand2 : bus.Operand2;

    // acc_q holds {product_hi, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, opnd_q};
        prod_fix = neg_res_q ? -acc_q : acc_q;
        acc_d    = {add_sum, acc_q[WIDTH-1:1]};
        if (is_div_q) begin
            if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else              acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        res1_d = prod_fix[WIDTH-1:0];
        res2_d = prod_fix[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            if (dz_q) begin
                res1_d = '1;
                res2_d = op1_raw_q;
            end else begin
                res1_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                res2_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op1_raw_q <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            result1_q <= '0;
            result2_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        is_div_q  <= bus.MCycleOp;
                        opnd_q    <= bus.MCycleOp ? mag2 : mag1;
                        acc_q     <= {{WIDTH{1'b0}}, (bus.MCycleOp ? mag1 : mag2)};
                        op1_raw_q <= bus.Operand1;
                        neg_res_q <= bus.Signed & (bus.Operand1[WIDTH-1] ^ bus.Operand2[WIDTH-1]);
                        neg_rem_q <= bus.Signed & bus.Operand1[WIDTH-1];
                        dz_q      <= (bus.Operand2 == '0);
                        cnt_q     <= '0;
                        state_q   <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= FIXUP;
                end
                FIXUP: begin
                    result1_q <= res1_d;
                    result2_q <= res2_d;
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Busy rises in the Start cycle itself so the issuing instruction stalls immediately
    assign bus.Busy    = !RESET && ((state_q != IDLE) || bus.Start);
    assign bus.Done    = done_q;
    assign bus.Result1 = result1_q;
    assign bus.Result2 = result2_q;
    assign state_o     = state_q;
endmodule
